gate_resp_compactor: RTL and testbench

GATE_RESP_COMPACTOR -- requirements
Module: gate_resp_compactor

---
 rtl/gate_sim_pkg.sv | 16 +
 rtl/gate_resp_compactor_misr_step.sv | 14 +
 rtl/gate_resp_compactor.sv | 94 +++++++++
 tb/tb_gate_resp_compactor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_sim_pkg.sv
// Shared definitions for the gate-model response compactor: FSM encoding,
// default response width/seed and the MISR feedback tap.
package gate_sim_pkg;

  localparam int         RESP_W_DEF = 10;
  localparam logic [9:0] SEED_DEF   = 10'h3FF;
  // Second feedback tap of x^10+x^7+1 (the first is the MSB).
  localparam int         MISR_TAP   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gate_resp_compactor_misr_step.sv
// One combinational step of the response MISR: shift left with MSB^tap
// feedback into bit 0, then fold in the new response vector.
module misr_step #(
  parameter int RESP_W = 10,
  parameter int TAP    = 6
) (
  input  logic [RESP_W-1:0] sig,
  input  logic [RESP_W-1:0] resp,
  output logic [RESP_W-1:0] nxt
);

  assign nxt = {sig[RESP_W-2:0], sig[RESP_W-1] ^ sig[TAP]} ^ resp;

endmodule

// File: rtl/gate_resp_compactor.sv
// Compacts a counted stream of gate-model responses into a MISR signature
// and compares it with a golden value at the end of the run.
module gate_resp_compactor
  import gate_sim_pkg::*;
#(
  parameter int                RESP_W = RESP_W_DEF,
  parameter int                CNT_W  = 16,
  parameter logic [RESP_W-1:0] SEED   = RESP_W'(SEED_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [RESP_W-1:0] golden,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp,
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [RESP_W-1:0] signature,
  output logic [CNT_W-1:0]  count
);

  state_t              state;
  logic [CNT_W-1:0]    num_lat;
  logic [RESP_W-1:0]   golden_lat;
  logic [RESP_W-1:0]   sig_next;
  logic [CNT_W-1:0]    cnt_next;
  logic                xfer;

  assign xfer     = resp_valid && resp_ready;
  // count < num_lat whenever a transfer happens, so this never wraps.
  assign cnt_next = count + CNT_W'(1);

  misr_step #(
    .RESP_W (RESP_W),
    .TAP    (MISR_TAP)
  ) u_misr (
    .sig  (signature),
    .resp (resp),
    .nxt  (sig_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      signature  <= SEED;
      count      <= '0;
      pass       <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      resp_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_RUN;
            busy       <= 1'b1;
            resp_ready <= (num_patterns != '0);
            signature  <= SEED;
            count      <= '0;
            pass       <= 1'b0;
            num_lat    <= num_patterns;
            golden_lat <= golden;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            signature <= sig_next;
            count     <= cnt_next;
            if (cnt_next == num_lat) begin
              state      <= ST_DONE;
              busy       <= 1'b0;
              resp_ready <= 1'b0;
              done       <= 1'b1;
              pass       <= (sig_next == golden_lat);
            end
          end else if (count == num_lat) begin
            // Only reachable for an empty run: signature is still SEED.
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (signature == golden_lat);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_resp_compactor.sv
// Self-checking bench for gate_resp_compactor: constant-vector table,
// randomized runs against a signature model, and hand-written corner cases.
module tb_gate_resp_compactor;

  localparam logic [9:0] SEED_V = 10'h3FF;

  logic        clk = 1'b0;
  logic        rst, start, resp_valid;
  logic [15:0] num_patterns;
  logic [9:0]  golden, resp;
  logic        resp_ready, busy, done, pass;
  logic [9:0]  signature;
  logic [15:0] count;

  int n_cmp  = 0;
  int n_fail = 0;

  gate_resp_compactor dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_patterns (num_patterns),
    .golden       (golden),
    .resp_valid   (resp_valid),
    .resp         (resp),
    .resp_ready   (resp_ready),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature),
    .count        (count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         num;
    logic [9:0] gold;
    logic [9:0] rsp;
    logic [9:0] exp_sig;
    logic       exp_pass;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Signature rule: multiply by x, reduce with x^10+x^7+1 feedback into bit 0, add response.
  function automatic logic [9:0] misr_ref(input logic [9:0] s, input logic [9:0] r);
    int v, fb;
    v  = int'(s);
    fb = ((v >> 9) ^ (v >> 6)) & 1;
    return 10'((((v << 1) | fb) & 'h3FF) ^ int'(r));
  endfunction

  // mode 0: valid every cycle, 1: valid on alternate cycles, 2: random valid and data.
  task automatic do_run(input int num, input logic [9:0] gold, input int mode,
                        input logic [9:0] fixed, input bit poke, output logic [9:0] sig_m);
    int cnt, cyc;
    logic [9:0] r;
    bit v;
    sig_m = SEED_V;
    cnt = 0;
    cyc = 0;
    start = 1'b1; num_patterns = 16'(num); golden = gold; resp_valid = 1'b0;
    tick();
    start = 1'b0;
    chk("run_busy", 32'(busy), 32'(1));
    while (cnt < num) begin
      chk("no_early_done", 32'(done), 32'(0));
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(99) < 60);
      endcase
      r = (mode == 2) ? 10'($urandom) : fixed;
      if (poke) begin
        start = cyc[0];
        num_patterns = 16'($urandom);
        golden = 10'($urandom);
      end
      resp_valid = v;
      resp = r;
      chk("ready_in_run", 32'(resp_ready), 32'(1));
      if (v) begin
        sig_m = misr_ref(sig_m, r);
        cnt++;
      end
      tick();
      cyc++;
      if (cyc > 4 * num + 40) begin
        n_cmp++;
        n_fail++;
        $display("FAIL run_timeout: got %0d transfers, expected %0d", cnt, num);
        break;
      end
    end
    resp_valid = 1'b0;
    start = 1'b0;
    if (num == 0) begin
      chk("empty_no_done_yet", 32'(done), 32'(0));
      tick();
    end
    chk("done_pulse", 32'(done), 32'(1));
    chk("done_busy", 32'(busy), 32'(0));
    chk("done_ready", 32'(resp_ready), 32'(0));
    chk("done_sig", 32'(signature), 32'(sig_m));
    chk("done_count", 32'(count), 32'(num));
    chk("done_pass", 32'(pass), 32'(sig_m == gold));
    tick();
    chk("done_one_cycle", 32'(done), 32'(0));
    chk("pass_held", 32'(pass), 32'(sig_m == gold));
    chk("idle_busy", 32'(busy), 32'(0));
  endtask

  vec_t vecs[$];
  logic [9:0] sm;

  initial begin
    rst = 1'b1; start = 1'b0; resp_valid = 1'b0;
    num_patterns = '0; golden = '0; resp = '0;

    // Vectors with hand-derived signatures for constant responses.
    vecs.push_back('{1, 10'h3FE, 10'h000, 10'h3FE, 1'b1});
    vecs.push_back('{2, 10'h3FC, 10'h000, 10'h3FC, 1'b1});
    vecs.push_back('{2, 10'h3FD, 10'h000, 10'h3FC, 1'b0});
    vecs.push_back('{0, 10'h3FF, 10'h000, 10'h3FF, 1'b1});
    vecs.push_back('{0, 10'h000, 10'h000, 10'h3FF, 1'b0});
    vecs.push_back('{1, 10'h001, 10'h3FF, 10'h001, 1'b1});

    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_pass", 32'(pass), 32'(0));
    chk("rst_ready", 32'(resp_ready), 32'(0));
    chk("rst_sig", 32'(signature), 32'(SEED_V));
    chk("rst_count", 32'(count), 32'(0));

    foreach (vecs[i]) begin
      do_run(vecs[i].num, vecs[i].gold, 0, vecs[i].rsp, 1'b0, sm);
      chk("tbl_sig", 32'(signature), 32'(vecs[i].exp_sig));
      chk("tbl_pass", 32'(pass), 32'(vecs[i].exp_pass));
    end

    // Alternating valid: exactly three transfers, ready drops after the third.
    do_run(3, 10'h000, 1, 10'h155, 1'b0, sm);
    chk("alt_count", 32'(count), 32'(3));

    // Randomized runs against the signature model.
    for (int k = 0; k < 10; k++)
      do_run(int'($urandom_range(1, 25)), 10'($urandom), 2, 10'h000, 1'b0, sm);
    do_run(300, 10'h000, 2, 10'h000, 1'b0, sm);

    // start re-asserted during RUN must not disturb the run.
    do_run(6, 10'h2A5, 0, 10'h0F3, 1'b1, sm);
    chk("poke_sig", 32'(signature), 32'(10'h0F3 ^ misr_ref(misr_ref(misr_ref(misr_ref(misr_ref(
        misr_ref(SEED_V, 10'h0F3), 10'h0F3), 10'h0F3), 10'h0F3), 10'h0F3), 10'h000)));

    // Reset after 2 of 5 transfers aborts the run; rst also beats start/valid.
    start = 1'b1; num_patterns = 16'd5; golden = 10'h000;
    tick();
    start = 1'b0; resp_valid = 1'b1; resp = 10'h0AA;
    tick(); tick();
    chk("abort_pre_count", 32'(count), 32'(2));
    rst = 1'b1; start = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_sig", 32'(signature), 32'(SEED_V));
    chk("abort_count", 32'(count), 32'(0));
    chk("abort_ready", 32'(resp_ready), 32'(0));
    chk("abort_pass", 32'(pass), 32'(0));
    rst = 1'b0; start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'(0));
      chk("abort_idle", 32'(busy), 32'(0));
    end
    resp_valid = 1'b0;

    // start held in DONE is ignored; valid in IDLE changes nothing.
    start = 1'b1; num_patterns = 16'd1; golden = 10'h000;
    tick();
    start = 1'b0; resp_valid = 1'b1; resp = 10'h000;
    tick();
    chk("seq_done", 32'(done), 32'(1));
    resp_valid = 1'b0; start = 1'b1; num_patterns = 16'd3;
    tick();
    chk("start_in_done_ignored", 32'(busy), 32'(0));
    start = 1'b0; resp_valid = 1'b1; resp = 10'h1C3;
    tick(); tick();
    chk("idle_valid_sig", 32'(signature), 32'(10'h3FE));
    chk("idle_valid_count", 32'(count), 32'(1));
    chk("idle_valid_ready", 32'(resp_ready), 32'(0));
    resp_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
